// File: rtl/program_loader.sv
// Framed byte-stream boot loader: assembles little-endian 32-bit words, writes
// them to program memory and holds the core in program mode while loading.
module program_loader #(
  parameter int         INSTR_ADDR_WIDTH = 8,
  parameter int         TIMEOUT_CYCLES   = 100000,
  parameter logic [7:0] START_BYTE       = 8'hA5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_valid,
  input  logic [7:0]                  rx_data,
  output logic                        rx_ready,
  output logic                        pgm,
  output logic                        pm_we,
  output logic [INSTR_ADDR_WIDTH-1:0] pm_addr,
  output logic [31:0]                 pm_wdata,
  output logic                        load_done,
  output logic                        load_error,
  output logic [15:0]                 word_count
);

  localparam int          TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0] DEPTH = 17'(1) << INSTR_ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK} state_t;

  state_t                      state_reg, state_next;
  logic [15:0]                 len_reg, len_next;
  logic [1:0]                  idx_reg, idx_next;
  logic [7:0]                  chk_reg, chk_next;
  logic [TW-1:0]               timer_reg, timer_next;
  logic [23:0]                 word_reg, word_next;
  logic                        pgm_reg, pgm_next;
  logic [INSTR_ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [31:0]                 wdata_reg, wdata_next;
  logic                        done_reg, done_next;
  logic                        error_reg, error_next;
  logic [15:0]                 count_reg, count_next;

  logic        accept;
  logic        err_trig;
  logic [15:0] n_full;

  assign rx_ready   = (state_reg != WRITE);
  assign accept     = rx_valid && rx_ready;
  assign n_full     = {rx_data, len_reg[7:0]};
  assign pgm        = pgm_reg;
  assign pm_we      = (state_reg == WRITE);
  assign pm_addr    = addr_reg;
  assign pm_wdata   = wdata_reg;
  assign load_done  = done_reg;
  assign load_error = error_reg;
  assign word_count = count_reg;

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    idx_next   = idx_reg;
    chk_next   = chk_reg;
    timer_next = timer_reg;
    word_next  = word_reg;
    pgm_next   = pgm_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    done_next  = 1'b0;
    error_next = error_reg;
    count_next = count_reg;
    err_trig   = 1'b0;

    // Inactivity watchdog for the byte-receiving states; a byte always wins.
    if (state_reg inside {LEN_LO, LEN_HI, DATA, CHECK}) begin
      if (accept)
        timer_next = '0;
      else if (timer_reg == TMAX)
        err_trig = 1'b1;
      else
        timer_next = timer_reg + 1'b1;
    end else begin
      timer_next = '0;
    end

    case (state_reg)
      IDLE: begin
        if (accept && rx_data == START_BYTE) begin
          state_next = LEN_LO;
          pgm_next   = 1'b1;
          error_next = 1'b0;
          count_next = '0;
          chk_next   = '0;
          idx_next   = '0;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_next[7:0] = rx_data;
          state_next    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_next[15:8] = rx_data;
          if ({1'b0, n_full} > DEPTH)
            err_trig = 1'b1;
          else if (n_full == 16'd0)
            state_next = CHECK;
          else
            state_next = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          chk_next = chk_reg ^ rx_data;
          idx_next = idx_reg + 2'd1;
          case (idx_reg)
            2'd0: word_next[7:0]   = rx_data;
            2'd1: word_next[15:8]  = rx_data;
            2'd2: word_next[23:16] = rx_data;
            default: begin
              wdata_next = {rx_data, word_reg};
              addr_next  = count_reg[INSTR_ADDR_WIDTH-1:0];
              state_next = WRITE;
            end
          endcase
        end
      end
      WRITE: begin
        count_next = count_reg + 16'd1;
        idx_next   = '0;
        state_next = (16'(count_reg + 16'd1) == len_reg) ? CHECK : DATA;
      end
      CHECK: begin
        if (accept) begin
          if (rx_data == chk_reg) begin
            done_next  = 1'b1;
            pgm_next   = 1'b0;
            state_next = IDLE;
          end else begin
            err_trig = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Abort leaves already-written words in memory.
    if (err_trig) begin
      error_next = 1'b1;
      pgm_next   = 1'b0;
      state_next = IDLE;
      timer_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      len_reg   <= '0;
      idx_reg   <= '0;
      chk_reg   <= '0;
      timer_reg <= '0;
      word_reg  <= '0;
      pgm_reg   <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      idx_reg   <= idx_next;
      chk_reg   <= chk_next;
      timer_reg <= timer_next;
      word_reg  <= word_next;
      pgm_reg   <= pgm_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      done_reg  <= done_next;
      error_reg <= error_next;
      count_reg <= count_next;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a scoreboard of expected memory writes is filled as
// frames are sent and drained by a monitor watching pm_we.
module tb_program_loader;

  localparam int AW = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          pgm;
  logic          pm_we;
  logic [AW-1:0] pm_addr;
  logic [31:0]   pm_wdata;
  logic          load_done;
  logic          load_error;
  logic [15:0]   word_count;

  program_loader #(
    .INSTR_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES  (TO),
    .START_BYTE      (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .pgm       (pgm),
    .pm_we     (pm_we),
    .pm_addr   (pm_addr),
    .pm_wdata  (pm_wdata),
    .load_done (load_done),
    .load_error(load_error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] fw[$];
  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  int          exp_done = 0;

  // Write monitor: every pm_we must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst) begin
      if (pm_we) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: addr=%0d data=%08h, required no write", pm_addr, pm_wdata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (pm_addr !== e.addr || pm_wdata !== e.data) begin
            bad++;
            $display("FAIL write: addr=%0d data=%08h, required addr=%0d data=%08h",
                     pm_addr, pm_wdata, e.addr, e.data);
          end else begin
            $display("write addr=%0d data=%08h ok", pm_addr, pm_wdata);
          end
        end
      end
      if (load_done) done_cnt++;
    end
  end

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      total++;
      bad++;
      $display("FAIL rx_ready_wait: rx_ready=%b, required 1 within 8 cycles", rx_ready);
    end
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input bit corrupt);
    logic [7:0]  chk;
    logic [7:0]  by;
    logic [15:0] n;
    wr_t         e;
    chk = 8'h00;
    n   = 16'(fw.size());
    send_byte(8'hA5);
    total++;
    if (pgm !== 1'b1) begin
      bad++;
      $display("FAIL pgm_after_start: pgm=%b, required 1", pgm);
    end
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    foreach (fw[i]) begin
      e.addr = AW'(i);
      e.data = fw[i];
      exp_q.push_back(e);
      for (int b = 0; b < 4; b++) begin
        by  = fw[i][8*b +: 8];
        chk = chk ^ by;
        send_byte(by);
      end
    end
    total++;
    if (pgm !== 1'b1) begin
      bad++;
      $display("FAIL pgm_before_chk: pgm=%b, required 1", pgm);
    end
    send_byte(corrupt ? (chk ^ 8'h01) : chk);
    total++;
    if (!corrupt) begin
      exp_done++;
      if (load_done !== 1'b1 || pgm !== 1'b0 || load_error !== 1'b0) begin
        bad++;
        $display("FAIL frame_done: done=%b pgm=%b err=%b, required 1 0 0", load_done, pgm, load_error);
      end
    end else if (load_done !== 1'b0 || pgm !== 1'b0 || load_error !== 1'b1) begin
      bad++;
      $display("FAIL frame_error: done=%b pgm=%b err=%b, required 0 0 1", load_done, pgm, load_error);
    end
    total++;
    if (word_count !== n) begin
      bad++;
      $display("FAIL word_count: got %0d, required %0d", word_count, n);
    end
    $display("frame words=%0d corrupt=%0d chk=%02h done=%b err=%b", n, corrupt, chk, load_done, load_error);
    @(negedge clk);
    total++;
    if (load_done !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse_width: load_done=%b, required 0", load_done);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if (rx_ready !== 1'b1 || pgm !== 1'b0 || pm_we !== 1'b0 || pm_addr !== '0 ||
        pm_wdata !== 32'h0 || load_done !== 1'b0 || load_error !== 1'b0 || word_count !== 16'h0) begin
      bad++;
      $display("FAIL %s: rdy=%b pgm=%b we=%b addr=%0d wdata=%08h done=%b err=%b wc=%0d, required 1 0 0 0 0 0 0 0",
               tag, rx_ready, pgm, pm_we, pm_addr, pm_wdata, load_done, load_error, word_count);
    end else begin
      $display("%s outputs at reset values", tag);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_good_frame;
    fw = '{32'h00000013, 32'h00100093};
    send_frame(1'b0);
  endtask

  task automatic test_bad_checksum;
    fw = '{32'h00000013, 32'h00100093};
    send_frame(1'b1);
    send_byte(8'h13);
    total++;
    if (load_error !== 1'b1 || pgm !== 1'b0) begin
      bad++;
      $display("FAIL error_sticky: err=%b pgm=%b, required 1 0", load_error, pgm);
    end
    send_byte(8'hA5);
    total++;
    if (load_error !== 1'b0 || pgm !== 1'b1) begin
      bad++;
      $display("FAIL start_clears_error: err=%b pgm=%b, required 0 1", load_error, pgm);
    end
    $display("new start byte err=%b pgm=%b", load_error, pgm);
  endtask

  // Continues from the frame opened by test_bad_checksum: one length byte then stall.
  task automatic test_timeout;
    int i;
    send_byte(8'h02);
    i = 0;
    while (load_error !== 1'b1 && i < 40) begin
      @(negedge clk);
      i++;
    end
    total++;
    if (i != TO || load_error !== 1'b1 || pgm !== 1'b0 || rx_ready !== 1'b1) begin
      bad++;
      $display("FAIL timeout: cycles=%0d err=%b pgm=%b, required cycles=%0d err=1 pgm=0", i, load_error, pgm, TO);
    end else begin
      $display("timeout after %0d idle cycles", i);
    end
  endtask

  task automatic test_empty_frame;
    fw.delete();
    send_frame(1'b0);
  endtask

  task automatic test_too_long;
    send_byte(8'hA5);
    send_byte(8'h05);
    send_byte(8'h00);
    total++;
    if (load_error !== 1'b1 || pgm !== 1'b0 || word_count !== 16'h0) begin
      bad++;
      $display("FAIL too_long: err=%b pgm=%b wc=%0d, required 1 0 0", load_error, pgm, word_count);
    end else begin
      $display("N=5 rejected after length");
    end
    fw = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    send_frame(1'b0);
  endtask

  task automatic test_rst_mid_word;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("rst_mid_word");
    repeat (4) @(negedge clk);
    fw = '{32'hDEADBEEF};
    send_frame(1'b0);
  endtask

  task automatic test_back_to_back;
    fw = '{$urandom(), 32'h000000A5, $urandom(), 32'hA5A5A5A5};
    send_frame(1'b0);
    fw = '{$urandom()};
    send_frame(1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_timeout();
    test_empty_frame();
    test_too_long();
    test_rst_mid_word();
    test_back_to_back();
    repeat (4) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_writes: %0d outstanding, required 0", exp_q.size());
    end
    total++;
    if (done_cnt != exp_done) begin
      bad++;
      $display("FAIL done_count: got %0d pulses, required %0d", done_cnt, exp_done);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
